fetch_ctrl: RTL and testbench

//  Sequences instruction fetch: owns the PC register and the next-PC arbitration.

---
 rtl/fetch_ctrl_pkg.sv | 15 +
 rtl/fetch_pc_sel.sv | 32 +++
 rtl/fetch_ctrl.sv | 114 +++++++++++
 tb/tb_fetch_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_ctrl_pkg.sv
// rtl/fetch_ctrl_pkg.sv - shared widths, reset PC and FSM states for the fetch controller
package fetch_ctrl_pkg;

    localparam int unsigned      FC_ADDR_W   = 64;
    localparam int unsigned      FC_INST_W   = 32;
    localparam logic [63:0]      FC_PC_START = 64'h0000_0000_8000_0000;

    typedef enum logic [1:0] {
        FC_IDLE = 2'd0,
        FC_REQ  = 2'd1,
        FC_WAIT = 2'd2,
        FC_HOLD = 2'd3
    } fc_state_e;

endpackage

// File: rtl/fetch_pc_sel.sv
// rtl/fetch_pc_sel.sv - next-PC arbitration: trap over branch/jump over sequential advance
module fetch_pc_sel
    import fetch_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = FC_ADDR_W
) (
    input  logic              advance_i,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              trap_valid_i,
    input  logic [ADDR_W-1:0] trap_pc_i,
    input  logic              bj_ena_i,
    input  logic [ADDR_W-1:0] bj_target_i,
    output logic              redir_o,
    output logic [ADDR_W-1:0] next_pc_o
);

    logic [ADDR_W-1:0] target;

    always_comb begin
        target      = trap_valid_i ? trap_pc_i : bj_target_i;
        target[1:0] = 2'b00;
        redir_o     = trap_valid_i | bj_ena_i;
        if (redir_o) begin
            next_pc_o = target;
        end else if (advance_i) begin
            next_pc_o = pc_i + ADDR_W'(4);
        end else begin
            next_pc_o = pc_i;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - PC owner and single-outstanding instruction fetch sequencer
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int unsigned       ADDR_W   = FC_ADDR_W,
    parameter int unsigned       INST_W   = FC_INST_W,
    parameter logic [ADDR_W-1:0] PC_START = ADDR_W'(FC_PC_START)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              trap_valid,
    input  logic [ADDR_W-1:0] trap_pc,
    input  logic              bj_ena,
    input  logic [ADDR_W-1:0] bj_target,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [INST_W-1:0] imem_rsp_data,
    output logic              if_valid,
    input  logic              if_ready,
    output logic [ADDR_W-1:0] if_pc,
    output logic [INST_W-1:0] if_inst
);

    fc_state_e         state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] if_pc_q;
    logic [INST_W-1:0] if_inst_q;
    logic              kill_q;
    logic              req_valid_q;
    logic              if_valid_q;
    logic              redir;
    logic              advance;

    assign advance = (state_q == FC_HOLD) && if_ready;

    fetch_pc_sel #(
        .ADDR_W (ADDR_W)
    ) u_pc_sel (
        .advance_i    (advance),
        .pc_i         (pc_q),
        .trap_valid_i (trap_valid),
        .trap_pc_i    (trap_pc),
        .bj_ena_i     (bj_ena),
        .bj_target_i  (bj_target),
        .redir_o      (redir),
        .next_pc_o    (pc_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FC_IDLE;
            pc_q        <= PC_START;
            kill_q      <= 1'b0;
            req_valid_q <= 1'b0;
            if_valid_q  <= 1'b0;
            if_pc_q     <= '0;
            if_inst_q   <= '0;
        end else begin
            if (state_q != FC_IDLE) begin
                pc_q <= pc_d;
            end
            case (state_q)
                FC_IDLE: begin
                    state_q     <= FC_REQ;
                    req_valid_q <= 1'b1;
                end
                FC_REQ: begin
                    // A redirect racing the acceptance marks the in-flight fetch as stale.
                    if (imem_req_ready) begin
                        state_q     <= FC_WAIT;
                        req_valid_q <= 1'b0;
                        kill_q      <= redir;
                    end
                end
                FC_WAIT: begin
                    if (imem_rsp_valid) begin
                        kill_q <= 1'b0;
                        if (redir || kill_q) begin
                            state_q     <= FC_REQ;
                            req_valid_q <= 1'b1;
                        end else begin
                            state_q    <= FC_HOLD;
                            if_valid_q <= 1'b1;
                            if_pc_q    <= pc_q;
                            if_inst_q  <= imem_rsp_data;
                        end
                    end else if (redir) begin
                        kill_q <= 1'b1;
                    end
                end
                FC_HOLD: begin
                    if (redir || if_ready) begin
                        state_q     <= FC_REQ;
                        req_valid_q <= 1'b1;
                        if_valid_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= FC_IDLE;
                end
            endcase
        end
    end

    assign imem_req_valid = req_valid_q;
    assign imem_req_addr  = pc_q;
    assign if_valid       = if_valid_q;
    assign if_pc          = if_pc_q;
    assign if_inst        = if_inst_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - directed vector table, reset sequences and randomized model check for fetch_ctrl
module tb_fetch_ctrl;

    localparam logic [63:0] BOOT = 64'h0000_0000_8000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        trap_valid = 1'b0;
    logic [63:0] trap_pc = '0;
    logic        bj_ena = 1'b0;
    logic [63:0] bj_target = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        if_valid;
    logic        if_ready = 1'b0;
    logic [63:0] if_pc;
    logic [31:0] if_inst;

    always #5 clk = ~clk;

    fetch_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .trap_valid     (trap_valid),
        .trap_pc        (trap_pc),
        .bj_ena         (bj_ena),
        .bj_target      (bj_target),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_pc          (if_pc),
        .if_inst        (if_inst)
    );

    typedef struct {
        logic        rdy;
        logic        rv;
        logic [31:0] rd;
        logic        ifr;
        logic        tv;
        logic [63:0] tpc;
        logic        bj;
        logic [63:0] bjt;
        logic        e_req;
        logic [63:0] e_addr;
        logic        e_if;
        logic [63:0] e_pc;
        logic [31:0] e_inst;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic vec_t mk(input logic rdy, input logic rv, input logic [31:0] rd, input logic ifr,
                                input logic tv, input logic [63:0] tpc, input logic bj, input logic [63:0] bjt,
                                input logic e_req, input logic [63:0] e_addr, input logic e_if,
                                input logic [63:0] e_pc, input logic [31:0] e_inst);
        vec_t v;
        v.rdy = rdy; v.rv = rv; v.rd = rd; v.ifr = ifr;
        v.tv = tv; v.tpc = tpc; v.bj = bj; v.bjt = bjt;
        v.e_req = e_req; v.e_addr = e_addr; v.e_if = e_if; v.e_pc = e_pc; v.e_inst = e_inst;
        return v;
    endfunction

    function automatic logic [31:0] imem_word(input logic [63:0] a);
        return a[31:0] ^ {a[47:32], a[63:48]} ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [63:0] rand_target();
        logic [63:0] t;
        if ($urandom_range(0, 3) == 0) begin
            t = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
        end else begin
            t = {32'h0, 32'h8000_0000 | ($urandom & 32'h000F_FFFF)};
        end
        return t;
    endfunction

    task automatic check(input string name, input logic ok, input string detail);
        n_vec++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: %s", name, detail);
        end
    endtask

    task automatic drive(input logic rdy, input logic rv, input logic [31:0] rd, input logic ifr,
                         input logic tv, input logic [63:0] tpc, input logic bj, input logic [63:0] bjt);
        imem_req_ready = rdy;
        imem_rsp_valid = rv;
        imem_rsp_data  = rd;
        if_ready       = ifr;
        trap_valid     = tv;
        trap_pc        = tpc;
        bj_ena         = bj;
        bj_target      = bjt;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        check("reset_state", !imem_req_valid && !if_valid && if_pc == 64'h0 && if_inst == 32'h0,
              $sformatf("got req=%0b if=%0b pc=%h inst=%h want 0 0 0 0", imem_req_valid, if_valid, if_pc, if_inst));
        rst_n = 1'b1;
    endtask

    // Random-phase reference state: architectural next-fetch PC and an imem with one slot.
    logic [63:0] exp_pc;
    logic        pend;
    logic [63:0] pend_addr;
    int          pend_dly;
    logic        p_ifv, p_ifr, p_redir;
    logic [63:0] p_pc;
    logic [31:0] p_inst;
    int          deliveries;

    initial begin
        do_reset();

        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 64'h8000_0000, 0, 0, 0));
        vecs.push_back(mk(0, 1, 32'h0000_0013, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 64'h8000_0000, 32'h0000_0013));
        vecs.push_back(mk(0, 1, 32'hBAD0_0001, 0, 0, 0, 0, 0, 0, 0, 1, 64'h8000_0000, 32'h0000_0013));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 64'h8000_0000, 32'h0000_0013));
        vecs.push_back(mk(0, 1, 32'hBAD0_0002, 0, 0, 0, 0, 0, 0, 0, 1, 64'h8000_0000, 32'h0000_0013));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 64'h8000_0000, 32'h0000_0013));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 64'h8000_0000, 32'h0000_0013));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 64'h8000_0004, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 64'h8000_1002, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 64'h8000_0100, 1, 64'h8000_2000, 1, 64'h8000_1000, 0, 0, 0));
        vecs.push_back(mk(0, 1, 32'hBAD0_0003, 0, 0, 0, 0, 0, 1, 64'h8000_0100, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 64'h8000_3000, 1, 64'h8000_0100, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 64'h8000_3000, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 64'h8000_3000, 0, 0, 0));
        vecs.push_back(mk(0, 1, 32'h0000_1111, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 1, 64'h8000_4000, 0, 0, 1, 64'h8000_3000, 32'h0000_1111));
        vecs.push_back(mk(1, 0, 0, 0, 1, 64'h8000_5003, 0, 0, 1, 64'h8000_4000, 0, 0, 0));
        vecs.push_back(mk(0, 1, 32'h0000_AAAA, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 64'h8000_5000, 0, 0, 0));
        vecs.push_back(mk(0, 1, 32'h2222_0000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 64'h8000_6000, 0, 0, 1, 64'h8000_5000, 32'h2222_0000));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 64'h8000_6000, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 64'h8000_7000, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 64'h8000_8000, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 32'h0000_5555, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 64'h8000_8000, 0, 0, 0));
        vecs.push_back(mk(0, 1, 32'h0000_6666, 0, 0, 0, 1, 64'h8000_9000, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 64'h8000_9000, 0, 0, 0));
        vecs.push_back(mk(0, 1, 32'h7777_0000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 64'h8000_9000, 32'h7777_0000));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 64'h8000_9004, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 32'h0000_8888, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 0));
        vecs.push_back(mk(0, 1, 32'h1234_5678, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 32'h1234_5678));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 64'h0, 0, 0, 0));

        foreach (vecs[i]) begin
            vec_t v;
            v = vecs[i];
            check($sformatf("row%0d", i),
                  (imem_req_valid == v.e_req) && (!v.e_req || imem_req_addr == v.e_addr) &&
                  (if_valid == v.e_if) && (!v.e_if || (if_pc == v.e_pc && if_inst == v.e_inst)),
                  $sformatf("got req=%0b addr=%h if=%0b pc=%h inst=%h want req=%0b addr=%h if=%0b pc=%h inst=%h",
                            imem_req_valid, imem_req_addr, if_valid, if_pc, if_inst,
                            v.e_req, v.e_addr, v.e_if, v.e_pc, v.e_inst));
            drive(v.rdy, v.rv, v.rd, v.ifr, v.tv, v.tpc, v.bj, v.bjt);
            @(negedge clk);
        end

        // Asynchronous reset while an instruction is held for decode.
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        drive(0, 1, 32'hCAFE_0001, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("hold_before_reset", if_valid && if_pc == 64'h0 && if_inst == 32'hCAFE_0001,
              $sformatf("got if=%0b pc=%h inst=%h want 1 0 cafe0001", if_valid, if_pc, if_inst));
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("async_reset", !if_valid && !imem_req_valid,
              $sformatf("got if=%0b req=%0b want 0 0", if_valid, imem_req_valid));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("restart", imem_req_valid && imem_req_addr == BOOT,
              $sformatf("got req=%0b addr=%h want 1 %h", imem_req_valid, imem_req_addr, BOOT));

        do_reset();
        exp_pc = BOOT;
        pend = 1'b0;
        pend_addr = '0;
        pend_dly = 0;
        p_ifv = 1'b0; p_ifr = 1'b0; p_redir = 1'b0; p_pc = '0; p_inst = '0;
        deliveries = 0;

        for (int c = 0; c < 4000; c++) begin
            logic        tv, bj, rdy, ifr, rv, redir, active;
            logic [63:0] tpc, bjt, tgt;
            logic [31:0] rd;

            if (pend) begin
                check("single_outstanding", !imem_req_valid,
                      $sformatf("cycle %0d got req=%0b with fetch in flight want 0", c, imem_req_valid));
            end
            if (p_ifv && p_redir) begin
                check("hold_flush", !if_valid, $sformatf("cycle %0d got if=%0b want 0", c, if_valid));
            end else if (p_ifv && !p_ifr) begin
                check("hold_stable", if_valid && if_pc == p_pc && if_inst == p_inst,
                      $sformatf("cycle %0d got if=%0b pc=%h inst=%h want 1 %h %h", c, if_valid, if_pc, if_inst, p_pc, p_inst));
            end

            tv  = ($urandom_range(0, 15) == 0);
            bj  = ($urandom_range(0, 7) == 0);
            tpc = rand_target();
            bjt = rand_target();
            rdy = ($urandom_range(0, 2) != 0);
            ifr = ($urandom_range(0, 1) != 0);
            if (pend && pend_dly == 0) begin
                rv = 1'b1;
                rd = imem_word(pend_addr);
            end else begin
                rv = !pend && ($urandom_range(0, 3) == 0);
                rd = $urandom;
            end
            drive(rdy, rv, rd, ifr, tv, tpc, bj, bjt);

            redir  = tv | bj;
            tgt    = tv ? tpc : bjt;
            tgt[1:0] = 2'b00;
            active = imem_req_valid | pend | if_valid;

            if (imem_req_valid && rdy && !redir) begin
                check("req_addr", imem_req_addr == exp_pc,
                      $sformatf("cycle %0d got addr=%h want %h", c, imem_req_addr, exp_pc));
            end
            if (if_valid) begin
                check("deliver", if_pc == exp_pc && if_inst == imem_word(if_pc),
                      $sformatf("cycle %0d got pc=%h inst=%h want pc=%h inst=%h", c, if_pc, if_inst, exp_pc, imem_word(exp_pc)));
                if (ifr && !redir) deliveries++;
            end

            if (active && redir) begin
                exp_pc = tgt;
            end else if (if_valid && ifr) begin
                exp_pc = exp_pc + 64'd4;
            end
            if (pend && rv) begin
                pend = 1'b0;
            end else if (pend) begin
                pend_dly--;
            end
            if (imem_req_valid && rdy) begin
                pend      = 1'b1;
                pend_addr = imem_req_addr;
                pend_dly  = $urandom_range(0, 2);
            end
            p_ifv   = if_valid;
            p_ifr   = ifr;
            p_redir = redir;
            p_pc    = if_pc;
            p_inst  = if_inst;

            @(negedge clk);
        end

        check("progress", deliveries >= 50, $sformatf("got %0d deliveries want at least 50", deliveries));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
